// File: rtl/adc_lane_pkg.sv
// adc_lane_pkg: constants shared by the lane transmitter and the receive path.
// Holds the board swizzle maps, training words, PRBS seed and FSM states.
package adc_lane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } lane_state_e;

  localparam logic [7:0] TRAIN_W0  = 8'h55;
  localparam logic [7:0] TRAIN_W1  = 8'hAA;
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  // LANE_MAP[grp][is_q][w]: wire bit w carries logical bit LANE_MAP[..][w].
  // Channel group is channel % 4. The receive side inverts the same table.
  localparam logic [2:0] LANE_MAP [4][2][8] = '{
    '{ '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
       '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7} },
    '{ '{3'd7, 3'd1, 3'd3, 3'd2, 3'd6, 3'd5, 3'd4, 3'd0},
       '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7} },
    '{ '{3'd6, 3'd5, 3'd1, 3'd2, 3'd4, 3'd7, 3'd0, 3'd3},
       '{3'd3, 3'd2, 3'd1, 3'd0, 3'd6, 3'd7, 3'd4, 3'd5} },
    '{ '{3'd0, 3'd3, 3'd1, 3'd2, 3'd6, 3'd7, 3'd4, 3'd5},
       '{3'd5, 3'd6, 3'd2, 3'd4, 3'd3, 3'd1, 3'd7, 3'd0} }
  };

endpackage

// File: rtl/adc_lane_tx_swizzle.sv
// adc_lane_swizzle: combinational board bit swizzle for one lane byte.
// GRP selects the channel group (channel % 4), IS_Q selects the Q table.
module adc_lane_swizzle
  import adc_lane_pkg::*;
#(
  parameter int GRP  = 0,
  parameter bit IS_Q = 1'b0
) (
  input  logic [7:0] i_byte,
  output logic [7:0] o_wire
);

  for (genvar w = 0; w < 8; w++) begin : g_bit
    assign o_wire[w] = i_byte[LANE_MAP[GRP][IS_Q][w]];
  end

endmodule

// File: rtl/adc_lane_tx.sv
// adc_lane_tx: 8-channel I/Q lane transmitter with IDLE/TRAIN/RUN sequencing.
// Optional PRBS7 source enabled by defining ADC_LANE_TX_PRBS_EN; without it
// src_sel is ignored and the sample stream is always used.
// Lane bytes are registered in logical order and swizzled on the way out.
module adc_lane_tx
  import adc_lane_pkg::*;
#(
  parameter int         TRAIN_LEN = 64,
  parameter logic [7:0] IDLE_WORD = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            src_sel,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [7:0][7:0] s_data_i,
  input  logic [7:0][7:0] s_data_q,
  output logic [7:0][7:0] tx_i_p,
  output logic [7:0][7:0] tx_i_n,
  output logic [7:0][7:0] tx_q_p,
  output logic [7:0][7:0] tx_q_n,
  output logic            tx_train,
  output logic [15:0]     underrun_cnt
);

  localparam logic [9:0] TRAIN_LAST = 10'(TRAIN_LEN - 1);

  lane_state_e     r_state, w_nstate;
  logic [9:0]      r_cnt, w_ncnt;
  logic            r_rst_ok;
  logic [7:0][7:0] r_lane_i, r_lane_q, w_nxt_i, w_nxt_q;
  logic [7:0][7:0] w_wire_i, w_wire_q;
  logic            w_src_prbs, w_accept, w_underrun;
  logic [7:0]      w_prbs_word;

`ifdef ADC_LANE_TX_PRBS_EN
  logic [6:0] r_prbs, w_prbs_nxt;

  assign w_src_prbs = src_sel;

  // Advance the x^7+x^6+1 LFSR eight steps; first generated bit lands in bit 7.
  always_comb begin
    logic [6:0] v_s;
    v_s         = r_prbs;
    w_prbs_word = '0;
    for (int j = 0; j < 8; j++) begin
      v_s            = {v_s[5:0], v_s[6] ^ v_s[5]};
      w_prbs_word[7-j] = v_s[0];
    end
    w_prbs_nxt = v_s;
  end

  // LFSR runs only while PRBS words are emitted; otherwise it sits at the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_prbs <= PRBS_SEED;
    else if (r_state == ST_RUN && w_src_prbs)   r_prbs <= w_prbs_nxt;
    else                                        r_prbs <= PRBS_SEED;
  end
`else
  logic w_unused_src_sel;
  assign w_unused_src_sel = src_sel;
  assign w_src_prbs       = 1'b0;
  assign w_prbs_word      = '0;
`endif

  assign s_ready    = (r_state == ST_RUN) & ~w_src_prbs;
  assign w_accept   = s_valid & s_ready;
  assign w_underrun = (r_state == ST_RUN) & ~w_src_prbs & ~s_valid;

  // Next state and training word counter (counter is zero on TRAIN entry).
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = '0;
    if (!enable) begin
      w_nstate = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (r_rst_ok) w_nstate = ST_TRAIN;
        ST_TRAIN: begin
          w_ncnt = r_cnt + 10'd1;
          if (r_cnt == TRAIN_LAST) w_nstate = ST_RUN;
        end
        ST_RUN:   w_nstate = ST_RUN;
        default:  w_nstate = ST_IDLE;
      endcase
    end
  end

  // Logical lane bytes for the next cycle; data only follows an accept.
  always_comb begin
    w_nxt_i = {8{IDLE_WORD}};
    w_nxt_q = {8{IDLE_WORD}};
    if (w_nstate == ST_TRAIN) begin
      w_nxt_i = {8{w_ncnt[0] ? TRAIN_W1 : TRAIN_W0}};
      w_nxt_q = {8{w_ncnt[0] ? TRAIN_W1 : TRAIN_W0}};
    end else if (w_nstate == ST_RUN && r_state == ST_RUN) begin
      if (w_src_prbs) begin
        w_nxt_i = {8{w_prbs_word}};
        w_nxt_q = {8{~w_prbs_word}};
      end else if (w_accept) begin
        w_nxt_i = s_data_i;
        w_nxt_q = s_data_q;
      end
    end
  end

  // State, lane register, training flag and saturating underrun counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rst_ok     <= 1'b0;
      r_lane_i     <= {8{IDLE_WORD}};
      r_lane_q     <= {8{IDLE_WORD}};
      tx_train     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      r_rst_ok <= 1'b1;
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      r_lane_i <= w_nxt_i;
      r_lane_q <= w_nxt_q;
      tx_train <= (w_nstate == ST_TRAIN);
      if (w_underrun && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_ch
    adc_lane_swizzle #(.GRP(k % 4), .IS_Q(1'b0)) u_swz_i (
      .i_byte (r_lane_i[k]),
      .o_wire (w_wire_i[k])
    );
    adc_lane_swizzle #(.GRP(k % 4), .IS_Q(1'b1)) u_swz_q (
      .i_byte (r_lane_q[k]),
      .o_wire (w_wire_q[k])
    );
    assign tx_i_p[k] = w_wire_i[k];
    assign tx_i_n[k] = ~w_wire_i[k];
    assign tx_q_p[k] = w_wire_q[k];
    assign tx_q_n[k] = ~w_wire_q[k];
  end

endmodule

// File: tb/tb_adc_lane_tx.sv
// tb_adc_lane_tx: directed bench for adc_lane_tx with TRAIN_LEN=4.
module tb_adc_lane_tx;

  logic            clk, rst_n, enable, src_sel, s_valid, s_ready, tx_train;
  logic [7:0][7:0] s_data_i, s_data_q, tx_i_p, tx_i_n, tx_q_p, tx_q_n;
  logic [15:0]     underrun_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Board wiring as listed for the lanes: wire bit w = logical bit MAP[grp][q][w].
  int MAP [4][2][8] = '{
    '{ '{0,1,2,3,4,5,6,7}, '{0,1,2,3,4,5,6,7} },
    '{ '{7,1,3,2,6,5,4,0}, '{0,2,1,3,4,6,5,7} },
    '{ '{6,5,1,2,4,7,0,3}, '{3,2,1,0,6,7,4,5} },
    '{ '{0,3,1,2,6,7,4,5}, '{5,6,2,4,3,1,7,0} }
  };

  adc_lane_tx #(.TRAIN_LEN(4), .IDLE_WORD(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .src_sel(src_sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_i(s_data_i), .s_data_q(s_data_q),
    .tx_i_p(tx_i_p), .tx_i_n(tx_i_n), .tx_q_p(tx_q_p), .tx_q_n(tx_q_n),
    .tx_train(tx_train), .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] swz(input logic [7:0] s, input int ch, input int q);
    logic [7:0] r;
    for (int w = 0; w < 8; w++) r[w] = s[MAP[ch % 4][q][w]];
    return r;
  endfunction

  function automatic logic [7:0] deswz(input logic [7:0] wv, input int ch, input int q);
    logic [7:0] r;
    r = '0;
    for (int w = 0; w < 8; w++) r[MAP[ch % 4][q][w]] = wv[w];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // All four lane buses against per-channel logical bytes.
  task automatic chk_bus(input string tag, input logic [7:0][7:0] li, input logic [7:0][7:0] lq);
    logic [7:0][7:0] ei, eq;
    for (int k = 0; k < 8; k++) begin
      ei[k] = swz(li[k], k, 0);
      eq[k] = swz(lq[k], k, 1);
    end
    chk({tag, "_ip"}, tx_i_p, ei);
    chk({tag, "_in"}, tx_i_n, ~ei);
    chk({tag, "_qp"}, tx_q_p, eq);
    chk({tag, "_qn"}, tx_q_n, ~eq);
  endtask

  task automatic chk_lanes(input string tag, input logic [7:0] wi, input logic [7:0] wq);
    chk_bus(tag, {8{wi}}, {8{wq}});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0][7:0] pa_i, pa_q, pb_i, pb_q;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; enable = 1'b0; src_sel = 1'b0; s_valid = 1'b0;
    s_data_i = '0; s_data_q = '0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_train", tx_train, 1'b0);
    chk("rst_urun", underrun_cnt, 16'h0000);
    chk("rst_i_n_ff", tx_i_n, 64'hFFFF_FFFF_FFFF_FFFF);
    chk_lanes("rst", 8'h00, 8'h00);

    // Release reset with enable already high: IDLE holds across the first edge.
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    step();
    chk("hold_idle", tx_train, 1'b0);
    for (int t = 0; t < 4; t++) begin
      step();
      chk("train_flag", tx_train, 1'b1);
      chk_lanes("train", t[0] ? 8'hAA : 8'h55, t[0] ? 8'hAA : 8'h55);
    end
    step();
    chk("run_train", tx_train, 1'b0);
    chk("run_ready", s_ready, 1'b1);
    chk_lanes("run_first", 8'h00, 8'h00);

    // Bundle A: channel 2 I carries 8'h01, which lands on wire bit 6.
    for (int k = 0; k < 8; k++) begin
      pa_i[k] = (k == 2) ? 8'h01 : 8'(8'h13 * (k + 1));
      pa_q[k] = 8'hC5 ^ 8'(k * 8'h21);
      pb_i[k] = 8'(8'h5A + k * 8'h1D);
      pb_q[k] = 8'(8'hF0 - k * 8'h0B);
    end
    s_valid = 1'b1; s_data_i = pa_i; s_data_q = pa_q;
    step();
    chk("swz_i2", tx_i_p[2], 8'h40);
    chk("rx_remap_i2", deswz(tx_i_p[2], 2, 0), 8'h01);
    chk_bus("dataA", pa_i, pa_q);
    chk("urun_after_A", underrun_cnt, 16'd0);
    s_data_i = pb_i; s_data_q = pb_q;
    step();
    chk_bus("dataB", pb_i, pb_q);

    // Five RUN cycles with nothing offered.
    s_valid = 1'b0;
    repeat (5) step();
    chk("urun5", underrun_cnt, 16'd5);
    chk_lanes("urun_idle", 8'h00, 8'h00);

`ifdef ADC_LANE_TX_PRBS_EN
    begin
      logic [6:0] lf;
      logic [7:0] wd;
      lf = 7'h7F;
      src_sel = 1'b1;
      #1;
      chk("prbs_ready", s_ready, 1'b0);
      for (int n = 0; n < 4; n++) begin
        for (int j = 0; j < 8; j++) begin
          lf = {lf[5:0], lf[6] ^ lf[5]};
          wd[7-j] = lf[0];
        end
        step();
        for (int k = 0; k < 8; k++) chk("prbs_i", deswz(tx_i_p[k], k, 0), wd);
        chk_lanes("prbs", wd, ~wd);
      end
      chk("prbs_urun", underrun_cnt, 16'd5);
      src_sel = 1'b0;
    end
`else
    src_sel = 1'b1; s_valid = 1'b1; s_data_i = pa_q; s_data_q = pa_i;
    #1;
    chk("nosel_ready", s_ready, 1'b1);
    step();
    chk_bus("nosel_data", pa_q, pa_i);
    src_sel = 1'b0; s_valid = 1'b0;
`endif

    // Drop enable from RUN, retrain, drop again at word 2, then full retrain.
    enable = 1'b0;
    step();
    chk("drop_run_train", tx_train, 1'b0);
    chk_lanes("drop_run", 8'h00, 8'h00);
    enable = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      chk_lanes("pretrain", t[0] ? 8'hAA : 8'h55, t[0] ? 8'hAA : 8'h55);
    end
    enable = 1'b0;
    step();
    chk("drop_mid_train", tx_train, 1'b0);
    chk_lanes("drop_mid", 8'h00, 8'h00);
    enable = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("retrain_flag", tx_train, 1'b1);
      chk_lanes("retrain", t[0] ? 8'hAA : 8'h55, t[0] ? 8'hAA : 8'h55);
    end
    step();
    chk("retrain_done", tx_train, 1'b0);
    chk("retrain_ready", s_ready, 1'b1);

    // Saturation of the underrun counter.
    repeat (65600) @(posedge clk);
    #1;
    chk("urun_sat", underrun_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_lane_tx.md
ADC_LANE_TX -- requirements
Module: adc_lane_tx

Interface
REQ-001 SHALL have parameter TRAIN_LEN, default 64, number of training words sent after enable (range 2..1023).
REQ-002 SHALL have parameter IDLE_WORD, default 8'h00, logical byte driven on every lane when no data is available.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable  in  1  level; 1 runs the transmitter, 0 returns it to IDLE.
REQ-006 SHALL have port src_sel  in  1  0 = sample stream, 1 = PRBS7 source.
REQ-007 SHALL have port s_valid  in  1  sample bundle valid.
REQ-008 SHALL have port s_ready  out  1  bundle accepted when s_valid & s_ready.
REQ-009 SHALL have port s_data_i  in  [7:0][7:0]  I sample per channel 0..7, natural bit order.
REQ-010 SHALL have port s_data_q  in  [7:0][7:0]  Q sample per channel 0..7, natural bit order.
REQ-011 SHALL have ports tx_i_p, tx_i_n, tx_q_p, tx_q_n  out  [7:0][7:0]  per-channel lane wires, board-swizzled.
REQ-012 SHALL have port tx_train  out  1  high while training words are on the lanes.
REQ-013 SHALL have port underrun_cnt  out  16  RUN cycles with no accepted bundle, saturating.

Function
REQ-014 SHALL implement FSM IDLE -> TRAIN -> RUN; IDLE->TRAIN when enable=1; TRAIN->RUN after TRAIN_LEN words; any state -> IDLE on the cycle after enable=0.
REQ-015 SHALL drive IDLE_WORD on all lanes in IDLE; tx_train=0.
REQ-016 SHALL drive logical 8'h55 then 8'hAA alternating (first word 8'h55) on all lanes in TRAIN; tx_train=1.
REQ-017 SHALL assert s_ready only in RUN with src_sel=0; bundle accepted at cycle N appears on lanes at cycle N+1 (one registered stage, no further buffering).
REQ-018 SHALL drive IDLE_WORD and increment underrun_cnt (saturating at 16'hFFFF) in each RUN cycle with src_sel=0 and no accepted bundle.
REQ-019 SHALL drive each _n lane as bitwise complement of its _p lane, every cycle.
REQ-020 SHALL swizzle every logical byte s before output as wire bit w = s[MAP[w]], listed w0..w7: channels 0,4 I and Q identity; channels 1,5 I 7,1,3,2,6,5,4,0; channels 1,5 Q 0,2,1,3,4,6,5,7; channels 2,6 I 6,5,1,2,4,7,0,3; channels 2,6 Q 3,2,1,0,6,7,4,5; channels 3,7 I 0,3,1,2,6,7,4,5; channels 3,7 Q 5,6,2,4,3,1,7,0.
REQ-021 SHALL apply the swizzle to data, training, idle and PRBS words alike, so the receive-side remap restores natural order.
REQ-022 SHALL count training words with a 10-bit counter cleared on entry to TRAIN; enable toggled low mid-TRAIN restarts training from word 0 on re-enable.
REQ-023 SHALL switch sources on src_sel change at the next word boundary without re-training; underrun_cnt not incremented while src_sel=1.

Reset
REQ-024 SHALL on rst_n=0 force state IDLE, s_ready=0, tx_train=0, underrun_cnt=0, all _p lanes to swizzled IDLE_WORD and _n lanes to its complement.
REQ-025 SHALL leave IDLE no earlier than the second rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with ADC_LANE_TX_PRBS_EN defined, output PRBS7 (x^7+x^6+1, seed 7'h7F, 8 bits per cycle, same sequence on all channels, Q sequence = I sequence inverted) in RUN when src_sel=1.
REQ-027 SHALL, without ADC_LANE_TX_PRBS_EN, keep the src_sel port but ignore it and behave as src_sel=0.

Structure
REQ-028 SHALL place the MAP tables, 8'h55/8'hAA training constants and FSM state enum in package adc_lane_pkg, shared with the receive path.
REQ-029 SHALL implement the swizzle as sub-module adc_lane_swizzle (parameterised by channel group, combinational), instantiated per channel and per I/Q.

Verification
REQ-030 SHALL verify reset: rst_n=0 -> tx_i_p[k]=swizzled 8'h00, tx_i_n[k]=8'hFF for all k, underrun_cnt=0.
REQ-031 SHALL verify training: enable=1, TRAIN_LEN=4 -> lanes carry 55,AA,55,AA (logical) with tx_train=1 for exactly 4 cycles, then s_ready=1.
REQ-032 SHALL verify swizzle: s_data_i[2]=8'h01 accepted -> tx_i_p[2]=8'h40 next cycle; passed through the receive remap -> 8'h01.
REQ-033 SHALL verify underrun: RUN with s_valid=0 for 5 cycles -> underrun_cnt=5, lanes=IDLE_WORD.
REQ-034 SHALL verify enable drop mid-TRAIN at word 2 then re-enable -> training restarts at 8'h55 with full TRAIN_LEN.
REQ-035 SHALL verify (PRBS_EN) src_sel=1 in RUN -> s_ready=0, de-swizzled I lanes match PRBS7 reference from seed 7'h7F.
